// File: rtl/sha256_stream.sv
// sha256_stream: multi-block SHA-256 compression engine with valid/ready streaming.
// The host supplies pre-padded 512-bit blocks, and the engine chains H across the blocks
// of one message. When DOUBLE_EN=1, it can optionally re-hash the digest in-engine (sha256d).
// UNROLL rounds are computed per clock.
// Ports:
//   clk, rst         clock (rising edge), async active-high reset
//   in_valid/ready   block handshake; in_ready is high only in IDLE
//   in_block         padded block, W0 at [511:480]
//   in_first/last    message boundaries; in_dbl is sampled with in_last
//   out_valid/ready  digest handshake; out_hash is held until it is accepted
//   out_hash         digest H0..H7, H0 at [255:224]
//   busy             high whenever the engine is not IDLE
module sha256_stream #(
   parameter int unsigned UNROLL    = 1,
   parameter int unsigned DOUBLE_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         in_dbl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_hash,
   output logic         busy
);

   localparam int unsigned WW  = 32;
   localparam int unsigned RCW = 6;
   localparam logic [RCW-1:0] RND_STEP = RCW'(UNROLL);
   localparam logic [RCW-1:0] RND_LAST = RCW'(64 - UNROLL);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
      $error("sha256_stream: illegal UNROLL=%0d (legal: 1,2,4,8,16)", UNROLL);
   end

   localparam logic [0:7][WW-1:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [0:63][WW-1:0] K_TAB = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [2:0] {S_IDLE, S_ROUND, S_FINAL, S_DBL_LOAD, S_OUT} state_t;

   function automatic logic [WW-1:0] bsig0(input logic [WW-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction
   function automatic logic [WW-1:0] bsig1(input logic [WW-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction
   function automatic logic [WW-1:0] ssig0(input logic [WW-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction
   function automatic logic [WW-1:0] ssig1(input logic [WW-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   state_t         state_q;
   logic [RCW-1:0] rnd_q;
   logic           chain_vld_q, last_q, dbl_q;
   logic           in_ready_q, out_valid_q, busy_q;
   logic [WW-1:0]  h_q [8];
   logic [WW-1:0]  v_q [8];     // working variables a..h
   logic [WW-1:0]  w_q [16];    // schedule window, w_q[0] = W[rnd_q]
   logic [WW-1:0]  v_d [8];
   logic [WW-1:0]  w_d [16];

   // UNROLL chained rounds. The window is extended by UNROLL fresh words, and the
   // next window is those words shifted down by UNROLL.
   always_comb begin
      logic [WW-1:0] e [16+UNROLL];
      logic [WW-1:0] s [8];
      logic [WW-1:0] t1, t2;
      t1 = '0;
      t2 = '0;
      for (int i = 0; i < 16; i++) e[i] = w_q[i];
      for (int j = 0; j < int'(UNROLL); j++)
         e[16+j] = ssig1(e[14+j]) + e[9+j] + ssig0(e[1+j]) + e[j];
      s = v_q;
      for (int u = 0; u < int'(UNROLL); u++) begin
         t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6]))
              + K_TAB[rnd_q + RCW'(u)] + e[u];
         t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
         s[7] = s[6];
         s[6] = s[5];
         s[5] = s[4];
         s[4] = s[3] + t1;
         s[3] = s[2];
         s[2] = s[1];
         s[1] = s[0];
         s[0] = t1 + t2;
      end
      v_d = s;
      for (int i = 0; i < 16; i++) w_d[i] = e[i + int'(UNROLL)];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rnd_q       <= '0;
         chain_vld_q <= 1'b0;
         last_q      <= 1'b0;
         dbl_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            h_q[i] <= '0;
            v_q[i] <= '0;
         end
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  for (int i = 0; i < 16; i++) w_q[i] <= in_block[32*(15-i) +: 32];
                  // A new message, or one without a live chain, starts from the IV.
                  for (int i = 0; i < 8; i++) begin
                     if (in_first || !chain_vld_q) begin
                        h_q[i] <= IV[i];
                        v_q[i] <= IV[i];
                     end else begin
                        v_q[i] <= h_q[i];
                     end
                  end
                  last_q     <= in_last;
                  dbl_q      <= (DOUBLE_EN != 0) && in_last && in_dbl;
                  rnd_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_ROUND;
               end
            end
            S_ROUND: begin
               v_q   <= v_d;
               w_q   <= w_d;
               rnd_q <= rnd_q + RND_STEP;
               if (rnd_q == RND_LAST) state_q <= S_FINAL;
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
               if (!last_q) begin
                  chain_vld_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  chain_vld_q <= 1'b0;
                  if (dbl_q) begin
                     state_q <= S_DBL_LOAD;
                  end else begin
                     out_valid_q <= 1'b1;
                     state_q     <= S_OUT;
                  end
               end
            end
            S_DBL_LOAD: begin
               // Second pass hashes the 256-bit digest as a single padded block.
               for (int i = 0; i < 8; i++) begin
                  w_q[i] <= h_q[i];
                  h_q[i] <= IV[i];
                  v_q[i] <= IV[i];
               end
               w_q[8] <= 32'h8000_0000;
               for (int i = 9; i < 15; i++) w_q[i] <= '0;
               w_q[15] <= 32'd256;
               dbl_q   <= 1'b0;
               rnd_q   <= '0;
               state_q <= S_ROUND;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  chain_vld_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_hash  = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_stream.sv
// tb_sha256_stream: self-checking bench for sha256_stream. Four instances are checked:
// UNROLL 1, 4 and 16, plus UNROLL 16 with DOUBLE_EN=0. A behavioural SHA-256 (padding,
// full 64-word schedule, compression) supplies the expected digests for random messages.
module tb_sha256_stream;

   localparam int NI = 4;
   localparam logic [255:0] H_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] H_448  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] H_GEN  = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
   localparam logic [255:0] H_ABCD = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
   localparam string S448 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

   typedef logic [511:0] blk_t;
   typedef blk_t blkq_t[$];
   typedef byte unsigned byteq_t[$];

   logic clk = 1'b0;
   logic rst;
   logic [NI-1:0]        in_valid_s, in_ready_s, in_first_s, in_last_s, in_dbl_s;
   logic [NI-1:0]        out_valid_s, out_ready_s, busy_s;
   logic [NI-1:0][511:0] in_block_s;
   logic [NI-1:0][255:0] out_hash_s;
   int cyc = 0;
   int nvec = 0;
   int nfail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sha256_stream #(
         .UNROLL   (g == 0 ? 1 : (g == 1 ? 4 : 16)),
         .DOUBLE_EN(g == 3 ? 0 : 1)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid_s[g]),
         .in_ready (in_ready_s[g]),
         .in_block (in_block_s[g]),
         .in_first (in_first_s[g]),
         .in_last  (in_last_s[g]),
         .in_dbl   (in_dbl_s[g]),
         .out_valid(out_valid_s[g]),
         .out_ready(out_ready_s[g]),
         .out_hash (out_hash_s[g]),
         .busy     (busy_s[g])
      );
   end

   function automatic int ur(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 4 : 16);
   endfunction
   function automatic bit de(input int d);
      return d != 3;
   endfunction
   function automatic int lat_of(input int d, input bit dbl);
      int n = 64 / ur(d);
      return (dbl && de(d)) ? 2 * n + 4 : n + 2;
   endfunction

   // ---------------- reference model ----------------
   localparam logic [0:7][31:0] IVT = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [0:63][31:0] KT = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_hash(input blk_t q[$]);
      logic [31:0] h [8];
      logic [31:0] w [64];
      logic [31:0] s [8];
      logic [31:0] t1, t2;
      for (int i = 0; i < 8; i++) h[i] = IVT[i];
      foreach (q[b]) begin
         for (int t = 0; t < 16; t++) w[t] = q[b][32*(15-t) +: 32];
         for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
         s = h;
         for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
            t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
            s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
         end
         for (int i = 0; i < 8; i++) h[i] = h[i] + s[i];
      end
      return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
   endfunction

   function automatic blkq_t pad(input byte unsigned m[$]);
      byte unsigned p[$];
      longint unsigned bits;
      blkq_t q;
      blk_t x;
      p = m;
      bits = 64'(m.size()) * 8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
      for (int b = 0; b < p.size() / 64; b++) begin
         for (int j = 0; j < 64; j++) x[511 - 8*j -: 8] = p[64*b + j];
         q.push_back(x);
      end
      return q;
   endfunction

   function automatic byteq_t str_bytes(input string s);
      byteq_t m;
      for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
      return m;
   endfunction

   function automatic byteq_t gen_bytes();
      logic [639:0] gh;
      byteq_t m;
      gh = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
      for (int j = 0; j < 80; j++) m.push_back(gh[639 - 8*j -: 8]);
      return m;
   endfunction

   function automatic logic [255:0] exp_of(input blk_t q[$], input bit dbl);
      logic [255:0] h;
      byteq_t m;
      h = ref_hash(q);
      if (dbl) begin
         for (int j = 0; j < 32; j++) m.push_back(h[255 - 8*j -: 8]);
         h = ref_hash(pad(m));
      end
      return h;
   endfunction

   // ---------------- checking / driving helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_block(input int d, input blk_t b, input bit first, input bit last,
                             input bit dbl, output int t_acc, output int waited);
      int n = 0;
      while (in_ready_s[d] !== 1'b1 && n < 400) begin tick(); n++; end
      chk($sformatf("d%0d/ready_timeout", d), 256'(n < 400), 256'(1));
      in_valid_s[d] = 1'b1;
      in_block_s[d] = b;
      in_first_s[d] = first;
      in_last_s[d]  = last;
      in_dbl_s[d]   = dbl;
      t_acc  = cyc;
      waited = n;
      tick();
      in_valid_s[d] = 1'b0;
      in_first_s[d] = 1'($urandom);
      in_last_s[d]  = 1'($urandom);
      in_dbl_s[d]   = 1'($urandom);
   endtask

   task automatic wait_ready(input int d, input int t_acc, input int gap, input string tag);
      int n = 0;
      while (in_ready_s[d] !== 1'b1 && n < 400) begin tick(); n++; end
      chk($sformatf("d%0d/%s/ready_gap", d, tag), 256'(cyc - t_acc), 256'(gap));
   endtask

   task automatic finish_msg(input int d, input logic [255:0] exp, input int lat,
                             input int hold, input int t_acc, input string tag);
      int n = 0;
      while (out_valid_s[d] !== 1'b1 && n < 400) begin tick(); n++; end
      chk($sformatf("d%0d/%s/latency", d, tag), 256'(cyc - t_acc), 256'(lat));
      chk($sformatf("d%0d/%s/hash", d, tag), out_hash_s[d], exp);
      chk($sformatf("d%0d/%s/in_ready_out", d, tag), 256'(in_ready_s[d]), 256'(0));
      chk($sformatf("d%0d/%s/busy_out", d, tag), 256'(busy_s[d]), 256'(1));
      for (int k = 0; k < hold; k++) begin
         tick();
         chk($sformatf("d%0d/%s/hold_valid", d, tag), 256'(out_valid_s[d]), 256'(1));
         chk($sformatf("d%0d/%s/hold_hash", d, tag), out_hash_s[d], exp);
         chk($sformatf("d%0d/%s/hold_in_ready", d, tag), 256'(in_ready_s[d]), 256'(0));
      end
      out_ready_s[d] = 1'b1;
      tick();
      out_ready_s[d] = 1'b0;
      chk($sformatf("d%0d/%s/valid_drop", d, tag), 256'(out_valid_s[d]), 256'(0));
      chk($sformatf("d%0d/%s/ready_back", d, tag), 256'(in_ready_s[d]), 256'(1));
      chk($sformatf("d%0d/%s/busy_idle", d, tag), 256'(busy_s[d]), 256'(0));
   endtask

   task automatic run_msg(input int d, input blk_t q[$], input bit first0, input bit dbl,
                          input logic [255:0] exp, input int hold, input string tag);
      int t, w;
      bit lst;
      for (int i = 0; i < q.size(); i++) begin
         lst = (i == q.size() - 1);
         // in_dbl on a non-final block must be ignored
         send_block(d, q[i], (i == 0) ? first0 : 1'b0, lst, lst ? dbl : 1'b1, t, w);
         if (!lst) wait_ready(d, t, 64 / ur(d) + 2, tag);
      end
      finish_msg(d, exp, lat_of(d, dbl), hold, t, tag);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      blkq_t q;
      byteq_t m;
      int t, w, hold;
      bit dbl, hrdy;
      logic [255:0] e;

      rst = 1'b1;
      in_valid_s = '0; in_first_s = '0; in_last_s = '0; in_dbl_s = '0;
      in_block_s = '0; out_ready_s = '0;
      repeat (3) tick();
      for (int d = 0; d < NI; d++) begin
         chk($sformatf("d%0d/rst_in_ready", d), 256'(in_ready_s[d]), 256'(0));
         chk($sformatf("d%0d/rst_out_valid", d), 256'(out_valid_s[d]), 256'(0));
         chk($sformatf("d%0d/rst_busy", d), 256'(busy_s[d]), 256'(0));
         chk($sformatf("d%0d/rst_hash", d), out_hash_s[d], 256'(0));
      end
      rst = 1'b0;
      tick();
      for (int d = 0; d < NI; d++) begin
         chk($sformatf("d%0d/idle_in_ready", d), 256'(in_ready_s[d]), 256'(1));
         chk($sformatf("d%0d/idle_busy", d), 256'(busy_s[d]), 256'(0));
      end

      // Known-answer vectors on every instance
      for (int d = 0; d < NI; d++) begin
         run_msg(d, pad(str_bytes("abc")), 1'b1, 1'b0, H_ABC, 0, "abc");
         run_msg(d, pad(str_bytes(S448)), 1'b1, 1'b0, H_448, 0, "two_block");
         q = pad(gen_bytes());
         run_msg(d, q, 1'b1, 1'b1, de(d) ? H_GEN : exp_of(q, 1'b0), 0, "genesis");
         run_msg(d, pad(str_bytes("abc")), 1'b1, 1'b1, de(d) ? H_ABCD : H_ABC, 0, "abc_dbl");
      end

      // Backpressure, then a new message straight after the output handshake
      q = pad(str_bytes("abc"));
      send_block(0, q[0], 1'b1, 1'b1, 1'b0, t, w);
      finish_msg(0, H_ABC, 66, 20, t, "backpressure");
      send_block(0, q[0], 1'b1, 1'b1, 1'b0, t, w);
      chk("d0/accept_after_out", 256'(w), 256'(0));
      finish_msg(0, H_ABC, 66, 0, t, "after_bp");

      // in_first mid-chain restarts from the IV
      q = pad(str_bytes(S448));
      send_block(1, q[0], 1'b1, 1'b0, 1'b0, t, w);
      wait_ready(1, t, 18, "restart_chain");
      run_msg(1, pad(str_bytes("abc")), 1'b1, 1'b0, H_ABC, 0, "restart");

      // Reset during round 30 of the first block
      send_block(0, q[0], 1'b1, 1'b0, 1'b0, t, w);
      repeat (30) tick();
      rst = 1'b1;
      tick();
      chk("d0/midrst_in_ready", 256'(in_ready_s[0]), 256'(0));
      chk("d0/midrst_out_valid", 256'(out_valid_s[0]), 256'(0));
      chk("d0/midrst_busy", 256'(busy_s[0]), 256'(0));
      chk("d0/midrst_hash", out_hash_s[0], 256'(0));
      rst = 1'b0;
      tick();
      run_msg(0, pad(str_bytes("abc")), 1'b0, 1'b0, H_ABC, 0, "post_rst");

      // Reset after a completed non-final block must drop the chain
      send_block(1, q[0], 1'b1, 1'b0, 1'b0, t, w);
      wait_ready(1, t, 18, "chain_then_rst");
      rst_pulse();
      run_msg(1, pad(str_bytes("abc")), 1'b0, 1'b0, H_ABC, 0, "chain_rst");

      // Random messages against the reference model
      for (int d = 0; d < NI; d++) begin
         for (int k = 0; k < 5; k++) begin
            m.delete();
            for (int i = 0; i < int'($urandom_range(0, 130)); i++) m.push_back(8'($urandom));
            dbl  = 1'($urandom);
            hrdy = 1'($urandom);
            hold = hrdy ? 0 : int'($urandom_range(0, 3));
            out_ready_s[d] = hrdy;
            q = pad(m);
            e = exp_of(q, dbl && de(d));
            run_msg(d, q, 1'b1, dbl, e, hold, $sformatf("rnd%0d_len%0d", k, m.size()));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
